// File: rtl/memtest_axil_slave_regs_if.sv
// AXI4-Lite bus bundle for the memtest register slave.
// The slave modport receives address/data/ready-for-response signals from
// the master and returns ready flags and response channels.
interface memtest_axil_slave_regs_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;

  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;

  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );
endinterface

// File: rtl/memtest_axil_slave_regs.sv
// AXI4-Lite slave with four 32-bit read/write registers.
// Write address and write data are held independently until both are
// present, then committed with byte strobes in a single cycle. Reads return
// the register value as it stood before the handshake edge, so a read that
// coincides with a commit to the same register sees the old contents.
module memtest_axil_slave_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  memtest_axil_slave_regs_if.slave        s_axi,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] reg_out
);
  localparam int DATA_W = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] regs [4];

  logic              aw_held;
  logic              w_held;
  logic [1:0]        aw_idx;
  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;

  logic              bvalid;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  logic              awready;
  logic              wready;
  logic              arready;
  logic              aw_fire;
  logic              w_fire;
  logic              ar_fire;
  logic              commit;

  // Protection bits, low address bits and any address bits above the
  // register index carry no meaning for this block.
  logic              unused_bits;

  // Replace only the byte lanes whose strobe is set.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] new_val,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  // Ready flags are forced low during reset so no handshake can sneak in.
  assign awready = !S_AXI_ARESET && !aw_held && !bvalid;
  assign wready  = !S_AXI_ARESET && !w_held && !bvalid;
  assign arready = !S_AXI_ARESET && !rvalid;

  assign aw_fire = s_axi.awvalid && awready;
  assign w_fire  = s_axi.wvalid && wready;
  assign ar_fire = s_axi.arvalid && arready;
  assign commit  = aw_held && w_held && !bvalid;

  assign s_axi.awready = awready;
  assign s_axi.wready  = wready;
  assign s_axi.arready = arready;
  assign s_axi.bvalid  = bvalid;
  assign s_axi.bresp   = 2'b00;
  assign s_axi.rvalid  = rvalid;
  assign s_axi.rdata   = rdata;
  assign s_axi.rresp   = 2'b00;

  assign reg_out = {regs[3], regs[2], regs[1], regs[0]};

  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr, s_axi.araddr};

  // Write control: hold flags for AW/W and the B response valid.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      bvalid  <= 1'b0;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      bvalid  <= 1'b1;
    end else begin
      if (aw_fire) aw_held <= 1'b1;
      if (w_fire) w_held <= 1'b1;
      if (bvalid && s_axi.bready) bvalid <= 1'b0;
    end
  end

  // Latch the accepted write address index and the write data/strobes.
  always_ff @(posedge S_AXI_ACLK) begin
    if (aw_fire) aw_idx <= s_axi.awaddr[3:2];
    if (w_fire) begin
      w_data <= s_axi.wdata;
      w_strb <= s_axi.wstrb;
    end
  end

  // Register file update on commit.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[aw_idx] <= merge_bytes(regs[aw_idx], w_data, w_strb);
    end
  end

  // Read channel: capture the pre-edge register value and hold until RREADY.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else if (ar_fire) begin
      rvalid <= 1'b1;
      rdata  <= regs[s_axi.araddr[3:2]];
    end else if (rvalid && s_axi.rready) begin
      rvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_memtest_axil_slave_regs.sv
// Directed bench for memtest_axil_slave_regs: a vector table of write/readback
// pairs plus hand-written sequences for handshake ordering, response
// back-pressure, read/commit collision and reset mid-transaction.
module tb_memtest_axil_slave_regs;
  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] reg_out;
  int           total = 0;
  int           bad = 0;

  memtest_axil_slave_regs_if #(.ADDR_W(4), .DATA_W(32)) bus ();

  memtest_axil_slave_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4)
  ) dut (
    .S_AXI_ACLK  (clk),
    .S_AXI_ARESET(rst),
    .s_axi       (bus),
    .reg_out     (reg_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic [3:0]  ra;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Full write transaction; called and returns on a falling edge.
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    bit b_done = 0;
    bus.awaddr = a; bus.awvalid = 1'b1;
    bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
    bus.bready = 1'b1;
    for (int n = 0; n < 20 && !b_done; n++) begin
      logic aw_f, w_f, b_f;
      aw_f = bus.awvalid && bus.awready;
      w_f  = bus.wvalid && bus.wready;
      b_f  = bus.bvalid && bus.bready;
      if (b_f) check("bresp", bus.bresp, 2'b00);
      @(negedge clk);
      if (aw_f) bus.awvalid = 1'b0;
      if (w_f) bus.wvalid = 1'b0;
      if (b_f) b_done = 1;
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    check("write_completed", b_done, 1);
  endtask

  // Full read transaction; called and returns on a falling edge.
  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    bit r_done = 0;
    d = '0;
    bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
    for (int n = 0; n < 20 && !r_done; n++) begin
      logic ar_f, r_f;
      ar_f = bus.arvalid && bus.arready;
      r_f  = bus.rvalid && bus.rready;
      if (r_f) begin
        d = bus.rdata;
        check("rresp", bus.rresp, 2'b00);
      end
      @(negedge clk);
      if (ar_f) bus.arvalid = 1'b0;
      if (r_f) r_done = 1;
    end
    bus.arvalid = 1'b0; bus.rready = 1'b0;
    check("read_completed", r_done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;

    vecs[0] = '{4'h0, 32'h0101FFFF, 4'hF, 4'h0, 32'h0101FFFF};
    vecs[1] = '{4'h4, 32'habcd0001, 4'hF, 4'h4, 32'habcd0001};
    vecs[2] = '{4'h8, 32'hdead0011, 4'hF, 4'h8, 32'hdead0011};
    vecs[3] = '{4'hC, 32'hbeef0011, 4'hF, 4'hC, 32'hbeef0011};
    vecs[4] = '{4'h4, 32'hFFFFFFFF, 4'hF, 4'h4, 32'hFFFFFFFF};
    vecs[5] = '{4'h4, 32'h00000000, 4'h5, 4'h4, 32'hFF00FF00};
    vecs[6] = '{4'h4, 32'h12345678, 4'h0, 4'h4, 32'hFF00FF00};
    vecs[7] = '{4'h7, 32'h5A5A5A5A, 4'h3, 4'h5, 32'hFF005A5A};
    vecs[8] = '{4'h0, 32'h00000000, 4'h8, 4'h1, 32'h0001FFFF};
    vecs[9] = '{4'hC, 32'h12340000, 4'hC, 4'hE, 32'h12340011};

    rst = 1'b1;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_awready", bus.awready, 0);
    check("rst_wready", bus.wready, 0);
    check("rst_arready", bus.arready, 0);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_reg_out", reg_out, 0);
    rst = 1'b0;
    #1;
    check("post_rst_awready", bus.awready, 1);
    check("post_rst_arready", bus.arready, 1);
    @(negedge clk);

    // Table-driven write / readback
    for (int i = 0; i < 10; i++) begin
      axi_write(vecs[i].wa, vecs[i].wd, vecs[i].ws);
      axi_read(vecs[i].ra, rd);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
      if (i == 3) check("reg_out_all4", reg_out, 128'hbeef0011_dead0011_abcd0001_0101FFFF);
    end

    // AW first, W three cycles later
    bus.awaddr = 4'h4; bus.awvalid = 1'b1;
    check("ord_aw_ready", bus.awready, 1);
    @(negedge clk);
    bus.awvalid = 1'b0;
    check("ord_aw_held", bus.awready, 0);
    repeat (2) @(negedge clk);
    bus.wdata = 32'h12345678; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    check("ord_w_ready", bus.wready, 1);
    @(negedge clk);
    bus.wvalid = 1'b0;
    check("ord_b_not_yet", bus.bvalid, 0);
    @(negedge clk);
    check("ord_b_set", bus.bvalid, 1);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check("ord_b_clear", bus.bvalid, 0);
    @(negedge clk);
    check("ord_b_single", bus.bvalid, 0);
    axi_read(4'h4, rd);
    check("ord_readback", rd, 32'h12345678);

    // W first, AW three cycles later
    bus.wdata = 32'hCAFE1234; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.wvalid = 1'b0;
    check("rev_w_held", bus.wready, 0);
    repeat (2) @(negedge clk);
    bus.awaddr = 4'h4; bus.awvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    check("rev_b_not_yet", bus.bvalid, 0);
    @(negedge clk);
    check("rev_b_set", bus.bvalid, 1);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    axi_read(4'h4, rd);
    check("rev_readback", rd, 32'hCAFE1234);

    // B back-pressure with a second write waiting
    bus.awaddr = 4'h0; bus.awvalid = 1'b1;
    bus.wdata = 32'h55AA55AA; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(negedge clk);
    bus.awaddr = 4'hC; bus.awvalid = 1'b1;
    bus.wdata = 32'h11112222; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d_bvalid", k), bus.bvalid, 1);
      check($sformatf("bp%0d_bresp", k), bus.bresp, 2'b00);
      check($sformatf("bp%0d_awready", k), bus.awready, 0);
      check($sformatf("bp%0d_wready", k), bus.wready, 0);
      @(negedge clk);
    end
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check("bp_b_clear", bus.bvalid, 0);
    check("bp_next_awready", bus.awready, 1);
    check("bp_next_wready", bus.wready, 1);
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(negedge clk);
    check("bp_second_b", bus.bvalid, 1);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    axi_read(4'h0, rd);
    check("bp_reg0", rd, 32'h55AA55AA);
    axi_read(4'hC, rd);
    check("bp_reg3", rd, 32'h11112222);

    // Read colliding with commit to the same register
    axi_write(4'h8, 32'h0000000A, 4'hF);
    bus.awaddr = 4'h8; bus.awvalid = 1'b1;
    bus.wdata = 32'h0000000B; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.araddr = 4'h8; bus.arvalid = 1'b1;
    @(negedge clk);
    bus.arvalid = 1'b0;
    check("col_rvalid", bus.rvalid, 1);
    check("col_rdata_old", bus.rdata, 32'h0000000A);
    check("col_bvalid", bus.bvalid, 1);
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0; bus.rready = 1'b0;
    axi_read(4'h8, rd);
    check("col_rdata_new", rd, 32'h0000000B);

    // Reset with B and R both pending
    bus.awaddr = 4'h4; bus.awvalid = 1'b1;
    bus.wdata = 32'h77777777; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.araddr = 4'h0; bus.arvalid = 1'b1;
    @(negedge clk);
    bus.arvalid = 1'b0;
    check("mid_bvalid", bus.bvalid, 1);
    check("mid_rvalid", bus.rvalid, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_bvalid", bus.bvalid, 0);
    check("mid_rst_rvalid", bus.rvalid, 0);
    check("mid_rst_rdata", bus.rdata, 0);
    check("mid_rst_reg_out", reg_out, 0);
    check("mid_rst_awready", bus.awready, 0);
    check("mid_rst_arready", bus.arready, 0);
    rst = 1'b0;
    bus.bready = 1'b1; bus.rready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("mid_post%0d_bvalid", k), bus.bvalid, 0);
      check($sformatf("mid_post%0d_rvalid", k), bus.rvalid, 0);
    end
    bus.bready = 1'b0; bus.rready = 1'b0;

    // Held AW discarded by reset; a later lone W must not produce a response
    bus.awaddr = 4'hC; bus.awvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.wdata = 32'h00000099; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("disc%0d_bvalid", k), bus.bvalid, 0);
      @(negedge clk);
    end
    bus.awaddr = 4'h8; bus.awvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    @(negedge clk);
    check("disc_commit_b", bus.bvalid, 1);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check("disc_reg_out", reg_out, {32'h0, 32'h00000099, 32'h0, 32'h0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/memtest_axil_slave_regs.md
MEMTEST_AXIL_SLAVE_REGS -- requirements
Module: memtest_axil_slave_regs

Interface
REQ-001 The block SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, fixing the AXI4-Lite data bus width.
REQ-002 The block SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, fixing the byte-address bus width.
REQ-003 S_AXI_ACLK  in  1  sole clock; all state SHALL change on its rising edge only.
REQ-004 S_AXI_ARESET  in  1  reset, synchronous and active-high.
REQ-005 S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address; S_AXI_AWPROT  in  3  ignored; S_AXI_AWVALID  in  1; S_AXI_AWREADY  out  1.
REQ-006 S_AXI_WDATA  in  32  write data; S_AXI_WSTRB  in  4  byte enables; S_AXI_WVALID  in  1; S_AXI_WREADY  out  1.
REQ-007 S_AXI_BRESP  out  2  write response; S_AXI_BVALID  out  1; S_AXI_BREADY  in  1.
REQ-008 S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address; S_AXI_ARPROT  in  3  ignored; S_AXI_ARVALID  in  1; S_AXI_ARREADY  out  1.
REQ-009 S_AXI_RDATA  out  32  read data; S_AXI_RRESP  out  2; S_AXI_RVALID  out  1; S_AXI_RREADY  in  1.
REQ-010 reg_out  out  128  concatenation {reg3,reg2,reg1,reg0} of the four 32-bit registers, registered.

Function
REQ-011 Register file: four 32-bit read/write registers, index = address bits [3:2]; address bits [1:0] SHALL be ignored.
REQ-012 Write address holder: aw_held flag + latched address; AWREADY = !aw_held && !BVALID; AW handshake (AWVALID&&AWREADY) sets aw_held and latches AWADDR.
REQ-013 Write data holder: w_held flag + latched data/strobe; WREADY = !w_held && !BVALID; W handshake latches WDATA and WSTRB.
REQ-014 AW and W SHALL be accepted in either order or the same cycle; a second AW (or W) SHALL NOT be accepted until the pending write commits.
REQ-015 Commit: on the first edge where aw_held && w_held && !BVALID, update selected register per byte (byte i written only if WSTRB[i]=1), clear both flags, set BVALID=1, BRESP=00.
REQ-016 Latency: AW and W both handshaken at edge N -> register updated and BVALID=1 after edge N+1.
REQ-017 BVALID SHALL hold with BRESP stable until the edge where BREADY=1, then clear; AWREADY/WREADY SHALL stay 0 while BVALID=1.
REQ-018 Read: ARREADY = !RVALID; on AR handshake at edge N, RDATA SHALL capture the selected register value as of before edge N and RVALID=1, RRESP=00 after edge N.
REQ-019 RVALID and RDATA SHALL hold stable until the edge where RREADY=1, then RVALID clears; max read throughput is one per two cycles.
REQ-020 Simultaneous commit and AR handshake to the same register in one cycle: RDATA SHALL return the pre-write value.
REQ-021 Read and write channels SHALL operate independently; neither SHALL stall the other.
REQ-022 BRESP and RRESP SHALL always be 2'b00 (OKAY); no SLVERR or DECERR is generated.
REQ-023 WSTRB=4'b0000 SHALL complete a normal write handshake with no register change.

Reset
REQ-024 While S_AXI_ARESET=1 at an edge: reg0..reg3=0, reg_out=0, aw_held=w_held=0, BVALID=RVALID=0, BRESP=RRESP=00, RDATA=0.
REQ-025 AWREADY, WREADY and ARREADY SHALL be 0 whenever S_AXI_ARESET=1.
REQ-026 Reset asserted mid-transaction (held AW/W, pending B or R) SHALL discard all pending state; no B or R beat issued for it after release.
REQ-027 First AW/W/AR handshake SHALL be possible on the first edge after reset deasserts.

Verification
REQ-028 Write 0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011 to addresses 0x0,0x4,0x8,0xC, read each back -> RDATA matches, all BRESP/RRESP=00, reg_out=0xbeef0011_dead0011_abcd0001_0101FFFF.
REQ-029 AW at cycle 1, W at cycle 4 (and reversed order) to 0x4 with 0x12345678 -> single BVALID one cycle after later handshake; readback 0x12345678.
REQ-030 reg1=0xFFFFFFFF, write 0x00000000 WSTRB=4'b0101 -> readback 0xFF00FF00; WSTRB=0 write -> unchanged.
REQ-031 BREADY held 0 for 5 cycles after commit -> BVALID, BRESP stable, AWREADY=WREADY=0 throughout; next write accepted after B handshake.
REQ-032 reg2=0xA, commit 0xB to reg2 in same cycle as AR to 0x8 -> RDATA=0xA; next read -> 0xB.
REQ-033 Assert reset while BVALID=1 and RVALID=1 with RREADY=0 -> both clear, registers 0, no responses after release.
